banked_memory_2r1w: RTL

//  Parametrised banked register-file memory: NUM_BANKS sectors of DEPTH words, one write port, two independent read ports.

---
 rtl/banked_memory_2r1w.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/banked_memory_2r1w.sv
// Banked 2-read/1-write register-file memory with a per-bank clear sequencer.
// Optional same-edge write-to-read forwarding: define MEMBANK_BYPASS_EN.
module banked_memory_2r1w #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int BANK_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd1_en,
  input  logic [BANK_W-1:0] rd1_bank,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_valid,
  input  logic              rd2_en,
  input  logic [BANK_W-1:0] rd2_bank,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  output logic              rd2_valid,
  input  logic              clr_start,
  input  logic [BANK_W-1:0] clr_bank,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH     = 2**ADDR_W;
  localparam int NUM_BANKS = 2**BANK_W;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_t;

  clr_state_t        state_q, state_d;
  logic [BANK_W-1:0] cbank_q, cbank_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

  logic              clr_accept;
  logic              clr_we;
  logic              guard;
  logic [BANK_W-1:0] guard_bank;
  logic              wr_ok;
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;

  always_comb begin
    state_d    = state_q;
    cbank_d    = cbank_q;
    cnt_d      = cnt_q;
    clr_accept = 1'b0;
    clr_we     = 1'b0;
    clr_busy   = 1'b0;
    clr_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d    = CLEAR;
          cbank_d    = clr_bank;
          cnt_d      = '0;
          clr_accept = 1'b1;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH-1))
          state_d = DONE;
      end
      DONE: begin
        clr_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The bank under clear is fenced from its start edge to its last zero write.
  always_comb begin
    guard      = reset_n && (clr_accept || state_q == CLEAR);
    guard_bank = (state_q == CLEAR) ? cbank_q : clr_bank;
    wr_ok      = wr_en && !(guard && wr_bank == guard_bank);
  end

  always_comb begin
    rd1_next = mem[rd1_bank][rd1_addr];
    if (guard && rd1_bank == guard_bank)
      rd1_next = '0;
`ifdef MEMBANK_BYPASS_EN
    else if (wr_ok && rd1_bank == wr_bank
             && rd1_addr == wr_addr)
      rd1_next = wr_data;
`endif
  end

  always_comb begin
    rd2_next = mem[rd2_bank][rd2_addr];
    if (guard && rd2_bank == guard_bank)
      rd2_next = '0;
`ifdef MEMBANK_BYPASS_EN
    else if (wr_ok && rd2_bank == wr_bank
             && rd2_addr == wr_addr)
      rd2_next = wr_data;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cbank_q   <= '0;
      cnt_q     <= '0;
      rd1_data  <= '0;
      rd1_valid <= 1'b0;
      rd2_data  <= '0;
      rd2_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cbank_q   <= cbank_d;
      cnt_q     <= cnt_d;
      rd1_valid <= rd1_en;
      rd2_valid <= rd2_en;
      if (rd1_en)
        rd1_data <= rd1_next;
      if (rd2_en)
        rd2_data <= rd2_next;
    end
  end

  // Never the same word: user writes to the cleared bank are dropped.
  always_ff @(posedge clock) begin
    if (wr_ok)
      mem[wr_bank][wr_addr] <= wr_data;
    if (clr_we && reset_n)
      mem[cbank_q][cnt_q] <= '0;
  end

endmodule
